imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  UART-driven boot loader for the instruction SRAM: receives a framed program
//  image byte-by-byte from the UART receiver, writes it word-by-word through the
//  Fetch stage's imem_din/imem_addr/imem_web port, and holds the core in reset
//  until a complete image with a valid checksum is loaded. Sits between uart_rx
//  and the top level (drives Fetch imem_* and the core reset).
// PARAMETERS
//  ADDR_WIDTH      5        imem word-address width; DEPTH = 2**ADDR_WIDTH words
//  SYNC_BYTE       8'hA5    frame start byte
//  TIMEOUT_CYCLES  1000000  max idle clk cycles between bytes inside a frame
// PORTS
//  clk           in   1   clock, all logic on posedge
//  rst           in   1   reset, asynchronous, active-low (0 = reset)
//  rx_data       in   8   received byte, valid when rx_valid=1
//  rx_valid      in   1   one-cycle strobe per received byte
//  imem_addr     out  32  byte address to imem (word index << 2)
//  imem_din      out  32  write data to imem
//  imem_web      out  1   imem write enable, active-low (0 = write this cycle)
//  core_rst      out  1   active-high reset to pipeline (drives Fetch rst etc.)
//  load_busy     out  1   1 while a frame is in progress
//  load_done     out  1   one-cycle pulse when an image is accepted
//  load_err      out  1   sticky error flag; cleared on next SYNC_BYTE
//  words_loaded  out  ADDR_WIDTH+1  words written in current/last frame
// BEHAVIOUR
//  Reset values: imem_web=1, imem_addr=0, imem_din=0, core_rst=1, load_busy=0,
//   load_done=0, load_err=0, words_loaded=0; FSM=IDLE, byte/word counters=0.
//  Frame: SYNC_BYTE, N (word count), 4*N data bytes little-endian, CSUM =
//   XOR of all 4*N data bytes. Word k goes to imem_addr = k<<2, k = 0..N-1.
//  States: IDLE -> CNT -> DATA -> CSUM -> RUN; ERR is transient (1 cycle) -> IDLE.
//   IDLE: core_rst=1; rx_valid & rx_data==SYNC_BYTE -> CNT, load_err<=0,
//     load_busy<=1, words_loaded<=0; other bytes ignored.
//   CNT: N==0 or N>DEPTH -> ERR; else latch N -> DATA.
//   DATA: shift byte into word buffer (byte 0 = bits[7:0]), XOR into checksum.
//     On 4th byte: next cycle imem_web=0, imem_din=word, imem_addr=k<<2 for
//     exactly one cycle, words_loaded<=k+1. After word N-1's 4th byte -> CSUM.
//     Write strobe is pipelined: bytes accepted every cycle with no stall.
//   CSUM: byte==checksum -> RUN with load_done=1 for one cycle, load_busy<=0;
//     mismatch -> ERR.
//   RUN: core_rst=0 (deasserts the cycle after entering RUN). SYNC_BYTE received
//     -> CNT, core_rst=1 next cycle (reload restarts core). Other bytes ignored.
//   ERR: load_err<=1, load_busy<=0, core_rst stays 1 -> IDLE. Already-written
//     words remain in imem (no rollback).
//  Timeout: in CNT/DATA/CSUM an idle counter reloads on every rx_valid; reaching
//   TIMEOUT_CYCLES-1 without a byte -> ERR.
//  imem_web is 1 in every cycle except the single write cycle; a pending write
//   always completes even if the FSM moves to CSUM/ERR the same cycle.
//  rx_valid while ERR: byte dropped. Reset asserted mid-frame: all state to reset
//   values immediately; partial frame discarded, core held in reset.
//  Widths: byte counter 2 bits, word counter ADDR_WIDTH+1 bits, timeout counter
//   $clog2(TIMEOUT_CYCLES) bits; no wrap possible since N<=DEPTH.
// STRUCTURE
//  Package loader_pkg: state enum typedef (IDLE,CNT,DATA,CSUM,RUN,ERR),
//   default SYNC_BYTE constant.
//  One sub-module: loader_timeout (reloadable down-counter, enable/reload/expired).
// TESTING
//  1 Reset then A5,02, 11 22 33 44, 55 66 77 88, CS=0x88 -> writes 0x44332211@0x00,
//    0x88776655@0x04 (imem_web=0 one cycle each), load_done pulse, core_rst->0.
//  2 Same frame with CS=0x00 -> load_err=1, core_rst stays 1, load_done never.
//  3 A5,00 and A5,0x21 (DEPTH=32) -> load_err=1, no imem_web=0 cycles.
//  4 A5,01,AA then silence TIMEOUT_CYCLES (bench TIMEOUT_CYCLES=16) -> load_err=1;
//    next A5 clears load_err.
//  5 In RUN send valid 1-word frame A5,01,01 00 00 00,01 -> core_rst=1 during
//    load, word 0x00000001@0x00, core_rst back to 0.
//  6 Bytes on consecutive cycles (rx_valid held 1), and rst=0 mid-DATA ->
//    no lost bytes; after reset outputs equal reset values, core_rst=1.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the UART boot loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CNT,
        DATA,
        CSUM,
        RUN,
        ERR
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/loader_timeout.sv
// Reloadable idle down-counter; flags expiry once it reaches zero while enabled.
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic reload,
    output logic expired
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= LOAD;
        end else if (reload) begin
            cnt <= LOAD;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = enable && (cnt == '0);

endmodule

// File: rtl/imem_loader.sv
// UART boot loader: parses SYNC/N/data/CSUM frames, writes imem words and
// holds the core in reset until a checksum-verified image has been loaded.
module imem_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_WIDTH     = 5,
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [31:0]           imem_addr,
    output logic [31:0]           imem_din,
    output logic                  imem_web,
    output logic                  core_rst,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_err,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int WW    = ADDR_WIDTH + 1;

    state_t        state, state_nxt;
    logic [1:0]    byte_cnt;
    logic [WW-1:0] word_cnt;
    logic [WW-1:0] n_words;
    logic [23:0]   word_buf;
    logic [7:0]    csum;

    logic is_sync, n_bad, last_byte, last_word;
    logic to_en, to_reload, to_expired;

    assign is_sync   = rx_valid && (rx_data == SYNC_BYTE);
    assign n_bad     = (rx_data == 8'd0) || (32'(rx_data) > 32'(DEPTH));
    assign last_byte = (byte_cnt == 2'd3);
    assign last_word = (word_cnt == (n_words - 1'b1));

    // Idle timer only runs while a frame is open; any received byte restarts it.
    assign to_en     = (state == CNT) || (state == DATA) || (state == CSUM);
    assign to_reload = rx_valid || !to_en;

    loader_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .enable  (to_en),
        .reload  (to_reload),
        .expired (to_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (is_sync) state_nxt = CNT;
            CNT: begin
                if (rx_valid)        state_nxt = n_bad ? ERR : DATA;
                else if (to_expired) state_nxt = ERR;
            end
            DATA: begin
                if (rx_valid) begin
                    if (last_byte && last_word) state_nxt = CSUM;
                end else if (to_expired) begin
                    state_nxt = ERR;
                end
            end
            CSUM: begin
                if (rx_valid)        state_nxt = (rx_data == csum) ? RUN : ERR;
                else if (to_expired) state_nxt = ERR;
            end
            RUN:     if (is_sync) state_nxt = CNT;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Write strobe is registered, so a word completing on the cycle the FSM
    // leaves DATA still gets its single imem_web=0 cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_web     <= 1'b1;
            imem_addr    <= '0;
            imem_din     <= '0;
            core_rst     <= 1'b1;
            load_busy    <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
            byte_cnt     <= '0;
            word_cnt     <= '0;
            n_words      <= '0;
            word_buf     <= '0;
            csum         <= '0;
        end else begin
            imem_web  <= 1'b1;
            load_done <= 1'b0;
            core_rst  <= (state != RUN);
            case (state)
                IDLE, RUN: begin
                    if (is_sync) begin
                        load_err     <= 1'b0;
                        load_busy    <= 1'b1;
                        words_loaded <= '0;
                        byte_cnt     <= '0;
                        word_cnt     <= '0;
                        csum         <= '0;
                    end
                end
                CNT: begin
                    if (rx_valid && !n_bad) n_words <= WW'(rx_data);
                end
                DATA: begin
                    if (rx_valid) begin
                        csum     <= csum ^ rx_data;
                        byte_cnt <= byte_cnt + 1'b1;
                        word_buf <= {rx_data, word_buf[23:8]};
                        if (last_byte) begin
                            imem_web     <= 1'b0;
                            imem_din     <= {rx_data, word_buf};
                            imem_addr    <= {{(32-WW-2){1'b0}}, word_cnt, 2'b00};
                            words_loaded <= word_cnt + 1'b1;
                            word_cnt     <= word_cnt + 1'b1;
                        end
                    end
                end
                CSUM: begin
                    if (rx_valid && (rx_data == csum)) begin
                        load_done <= 1'b1;
                        load_busy <= 1'b0;
                    end
                end
                ERR: begin
                    load_err  <= 1'b1;
                    load_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and randomized frames checked against a
// frame-level model of expected imem writes and status flags.
module tb_imem_loader;

    localparam int AW    = 5;
    localparam int DEPTH = 2 ** AW;
    localparam int TOC   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_din;
    logic        imem_web;
    logic        core_rst;
    logic        load_busy;
    logic        load_done;
    logic        load_err;
    logic [AW:0] words_loaded;

    imem_loader #(
        .ADDR_WIDTH     (AW),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TOC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .imem_addr    (imem_addr),
        .imem_din     (imem_din),
        .imem_web     (imem_web),
        .core_rst     (core_rst),
        .load_busy    (load_busy),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    logic [31:0] wq[$];

    always @(negedge clk) begin
        if (imem_web === 1'b0) begin
            got_addr.push_back(imem_addr);
            got_data.push_back(imem_din);
        end
        if (load_done === 1'b1) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int g;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        repeat (g) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_web"},   imem_web, 1);
        check({tag, "_addr"},  imem_addr, 0);
        check({tag, "_din"},   imem_din, 0);
        check({tag, "_crst"},  core_rst, 1);
        check({tag, "_busy"},  load_busy, 0);
        check({tag, "_done"},  load_done, 0);
        check({tag, "_err"},   load_err, 0);
        check({tag, "_words"}, 32'(words_loaded), 0);
    endtask

    // Frame-level model: a legal N writes every word (even with a bad checksum),
    // only a matching checksum yields load_done and releases the core.
    task automatic run_frame(input logic [7:0] n_byte, input logic [7:0] cs_xor,
                             input int maxgap, input string tag);
        logic [7:0] cs;
        logic [7:0] b;
        bit         valid;
        bit         good;
        int         n;
        valid = (n_byte != 8'd0) && (int'(n_byte) <= DEPTH);
        n     = valid ? int'(n_byte) : 0;
        good  = valid && (cs_xor == 8'd0);
        got_addr.delete();
        got_data.delete();
        done_cnt = 0;
        cs = 8'h00;
        send_byte(8'hA5, maxgap);
        send_byte(n_byte, maxgap);
        if (valid) begin
            check({tag, "_crst_loading"}, core_rst, 1);
            check({tag, "_busy_loading"}, load_busy, 1);
            for (int k = 0; k < n; k++) begin
                for (int j = 0; j < 4; j++) begin
                    b  = wq[k][8*j +: 8];
                    cs = cs ^ b;
                    send_byte(b, maxgap);
                end
            end
            send_byte(cs ^ cs_xor, maxgap);
        end
        repeat (4) begin
            @(posedge clk); #1;
        end
        check({tag, "_nwrites"}, got_addr.size(), n);
        for (int k = 0; k < n && k < got_addr.size(); k++) begin
            check({tag, "_addr"}, got_addr[k], 32'(k * 4));
            check({tag, "_data"}, got_data[k], wq[k]);
        end
        check({tag, "_done"},  done_cnt, good ? 1 : 0);
        check({tag, "_err"},   load_err, good ? 0 : 1);
        check({tag, "_crst"},  core_rst, good ? 0 : 1);
        check({tag, "_busy"},  load_busy, 0);
        check({tag, "_words"}, 32'(words_loaded), n);
    endtask

    initial begin
        logic [31:0] w;
        int nw;
        logic [7:0] cx;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        wq.delete();
        wq.push_back(32'h44332211);
        wq.push_back(32'h88776655);
        run_frame(8'h02, 8'h00, 0, "t1_good");

        run_frame(8'h02, 8'h88, 1, "t2_badcs");

        wq.delete();
        run_frame(8'h00, 8'h00, 0, "t3_n0");
        run_frame(8'h21, 8'h00, 0, "t3_n33");

        got_addr.delete();
        done_cnt = 0;
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'hAA, 0);
        for (int i = 0; i < 4 * TOC && load_err !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        check("t4_timeout_err",  load_err, 1);
        check("t4_timeout_crst", core_rst, 1);
        check("t4_timeout_done", done_cnt, 0);
        check("t4_timeout_busy", load_busy, 0);
        send_byte(8'hA5, 0);
        check("t4_sync_clears_err", load_err, 0);
        for (int i = 0; i < 4 * TOC && load_err !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        check("t4_second_timeout", load_err, 1);

        wq.delete();
        wq.push_back(32'hCAFEF00D);
        run_frame(8'h01, 8'h00, 2, "t5_first");
        wq.delete();
        wq.push_back(32'h00000001);
        run_frame(8'h01, 8'h00, 0, "t5_reload");

        wq.delete();
        for (int k = 0; k < DEPTH; k++) wq.push_back($urandom);
        run_frame(8'(DEPTH), 8'h00, 0, "t6_full_b2b");

        for (int f = 0; f < 8; f++) begin
            nw = int'($urandom_range(1, 6));
            cx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            wq.delete();
            for (int k = 0; k < nw; k++) begin
                w = $urandom;
                wq.push_back(w);
            end
            run_frame(8'(nw), cx, 3, "rand");
        end

        wq.delete();
        wq.push_back(32'h01020304);
        run_frame(8'h01, 8'h00, 0, "t6_pre");
        send_byte(8'hA5, 0);
        send_byte(8'h04, 0);
        for (int j = 0; j < 6; j++) send_byte(8'(8'h10 + j), 0);
        rst = 1'b0;
        #1;
        check_reset_values("t6_midreset");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6_after_crst", core_rst, 1);
        wq.delete();
        wq.push_back(32'hDEADBEEF);
        wq.push_back(32'h0BADC0DE);
        run_frame(8'h02, 8'h00, 0, "t6_recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
